mem_access: RTL and testbench

Memory-access stage sitting directly downstream of the execute-stage ALU. It accepts one instruction per handshake from EX (ALU result as address or pass-through value), performs at most one load or store over a single-outstanding request/grant/response bus, and delivers a registered one-cycle write-back beat to WB. Non-memory instructions pass through with one cycle of latency; memory instructions stall EX until the bus transaction completes or times out.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/mem_lane_align.sv | 39 +++
 rtl/mem_access.sv | 183 ++++++++++++++++++
 tb/tb_mem_access.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, size encodings and byte-enable helpers for mem_access
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned TIMEOUT_MAX = 65535;

  // Wide enough to hold TIMEOUT_CYCLES itself, so a grant on the last REQ cycle cannot wrap
  function automatic int unsigned timeout_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      default:   bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane replication/byte enables and load lane extraction/extension
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_sext,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  always_comb begin
    st_be = byte_enable(st_size, st_addr_lo);
    case (st_size)
      SIZE_BYTE: st_wdata = {4{st_data[7:0]}};
      SIZE_HALF: st_wdata = {2{st_data[15:0]}};
      default:   st_wdata = st_data;
    endcase
  end

  always_comb begin
    byte_shift = ld_rdata >> {ld_addr_lo, 3'b000};
    half_shift = ld_rdata >> {ld_addr_lo[1], 4'b0000};
    case (ld_size)
      SIZE_BYTE: ld_data = {{24{ld_sext & byte_shift[7]}}, byte_shift[7:0]};
      SIZE_HALF: ld_data = {{16{ld_sext & half_shift[15]}}, half_shift[15:0]};
      default:   ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access stage: EX handshake, single-outstanding bus, WB beat
// Optional MEM_MISALIGN_CHECK_EN: misaligned half/word accesses fail locally with memError.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exValid,
  output logic        exReady,
  input  logic [31:0] aluResult,
  input  logic [31:0] storeData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  size,
  input  logic        signExt,
  input  logic [4:0]  destReg,
  input  logic        regWrite,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  input  logic        memGnt,
  input  logic        memRvalid,
  input  logic [31:0] memRdata,
  output logic        wbValid,
  output logic [31:0] wbData,
  output logic [4:0]  wbDest,
  output logic        wbRegWrite,
  output logic        memError
);

  localparam int unsigned CNT_W = timeout_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [4:0]  dest_q;
  logic        regwrite_q;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;
  logic        accept, is_mem, misalign, start_bus;
  logic        done_store, done_load, timeout;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(size, aluResult[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign accept    = exValid && exReady;
  assign is_mem    = memRead || memWrite;
  assign start_bus = accept && is_mem && !misalign;

  mem_lane_align u_align (
    .st_size    (size),
    .st_addr_lo (aluResult[1:0]),
    .st_data    (storeData),
    .st_wdata   (st_wdata),
    .st_be      (st_be),
    .ld_size    (size_q),
    .ld_addr_lo (addr_lo_q),
    .ld_sext    (sext_q),
    .ld_rdata   (memRdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    exReady    = 1'b0;
    memReq     = 1'b0;
    done_store = 1'b0;
    done_load  = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        exReady = 1'b1;
        if (start_bus) state_nxt = REQ;
      end
      REQ: begin
        memReq = 1'b1;
        if (memGnt) begin
          if (memWe) begin
            done_store = 1'b1;
            state_nxt  = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end else if (cnt >= CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (memRvalid) begin
          done_load = 1'b1;
          state_nxt = IDLE;
        end else if (cnt >= CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once on accept and held stable until the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memWdata   <= '0;
      memBe      <= '0;
      addr_lo_q  <= '0;
      size_q     <= '0;
      sext_q     <= 1'b0;
      dest_q     <= '0;
      regwrite_q <= 1'b0;
    end else begin
      if (start_bus) begin
        cnt        <= '0;
        memWe      <= memWrite;
        memAddr    <= {aluResult[31:2], 2'b00};
        memWdata   <= st_wdata;
        memBe      <= st_be;
        addr_lo_q  <= aluResult[1:0];
        size_q     <= size;
        sext_q     <= signExt;
        dest_q     <= destReg;
        regwrite_q <= regWrite;
      end else if (state != IDLE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbValid    <= 1'b0;
      wbData     <= '0;
      wbDest     <= '0;
      wbRegWrite <= 1'b0;
      memError   <= 1'b0;
    end else begin
      wbValid  <= 1'b0;
      memError <= 1'b0;
      if (accept && (!is_mem || misalign)) begin
        wbValid    <= 1'b1;
        wbData     <= aluResult;
        wbDest     <= destReg;
        wbRegWrite <= regWrite && !misalign;
        memError   <= misalign;
      end else if (done_store) begin
        wbValid    <= 1'b1;
        wbDest     <= dest_q;
        wbRegWrite <= 1'b0;
      end else if (done_load) begin
        wbValid    <= 1'b1;
        wbData     <= ld_data;
        wbDest     <= dest_q;
        wbRegWrite <= regwrite_q;
      end else if (timeout) begin
        wbValid    <= 1'b1;
        wbDest     <= dest_q;
        wbRegWrite <= 1'b0;
        memError   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access (timeout set to 4 cycles)
module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic        exValid;
  logic        exReady;
  logic [31:0] aluResult;
  logic [31:0] storeData;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  size;
  logic        signExt;
  logic [4:0]  destReg;
  logic        regWrite;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memBe;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        wbValid;
  logic [31:0] wbData;
  logic [4:0]  wbDest;
  logic        wbRegWrite;
  logic        memError;

  int checks = 0;
  int errors = 0;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .exValid    (exValid),
    .exReady    (exReady),
    .aluResult  (aluResult),
    .storeData  (storeData),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .size       (size),
    .signExt    (signExt),
    .destReg    (destReg),
    .regWrite   (regWrite),
    .memReq     (memReq),
    .memWe      (memWe),
    .memAddr    (memAddr),
    .memWdata   (memWdata),
    .memBe      (memBe),
    .memGnt     (memGnt),
    .memRvalid  (memRvalid),
    .memRdata   (memRdata),
    .wbValid    (wbValid),
    .wbData     (wbData),
    .wbDest     (wbDest),
    .wbRegWrite (wbRegWrite),
    .memError   (memError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic sx, input logic [4:0] dst, input logic rw);
    exValid   = 1'b1;
    memRead   = rd;
    memWrite  = wr;
    size      = sz;
    aluResult = addr;
    storeData = sdata;
    signExt   = sx;
    destReg   = dst;
    regWrite  = rw;
    tick();
    exValid   = 1'b0;
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic [31:0] addr, input logic sx,
                      input logic [31:0] rdata, input logic [31:0] exp);
    issue(1'b1, 1'b0, sz, addr, 32'h0, sx, 5'd7, 1'b1);
    check({tag, "_req"}, memReq, 1);
    memGnt = 1'b1;
    tick();
    memGnt    = 1'b0;
    check({tag, "_wait_nowb"}, wbValid, 0);
    memRvalid = 1'b1;
    memRdata  = rdata;
    tick();
    memRvalid = 1'b0;
    check({tag, "_wbv"}, wbValid, 1);
    check({tag, "_data"}, wbData, exp);
    check({tag, "_dest"}, wbDest, 7);
    check({tag, "_rw"}, wbRegWrite, 1);
  endtask

  initial begin
    rst_n = 1'b0; exValid = 1'b0; aluResult = '0; storeData = '0; memRead = 1'b0; memWrite = 1'b0;
    size = 2'b00; signExt = 1'b0; destReg = '0; regWrite = 1'b0;
    memGnt = 1'b0; memRvalid = 1'b0; memRdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_ready", exReady, 1);
    check("rst_req", memReq, 0);
    check("rst_addr", memAddr, 0);
    check("rst_be", memBe, 0);
    check("rst_wdata", memWdata, 0);
    check("rst_wbv", wbValid, 0);
    check("rst_wbdata", wbData, 0);

    // Non-memory ops back to back
    issue(1'b0, 1'b0, 2'b10, 32'h1234_5678, 32'h0, 1'b0, 5'd3, 1'b1);
    check("alu_wbv", wbValid, 1);
    check("alu_data", wbData, 32'h1234_5678);
    check("alu_dest", wbDest, 3);
    check("alu_rw", wbRegWrite, 1);
    check("alu_req", memReq, 0);
    issue(1'b0, 1'b0, 2'b10, 32'hCAFE_0001, 32'h0, 1'b0, 5'd9, 1'b0);
    check("alu2_wbv", wbValid, 1);
    check("alu2_data", wbData, 32'hCAFE_0001);
    check("alu2_rw", wbRegWrite, 0);
    tick();
    check("alu_pulse", wbValid, 0);

    // Store byte at 0x1003, grant after two wait cycles
    issue(1'b0, 1'b1, 2'b00, 32'h0000_1003, 32'h0000_00AB, 1'b0, 5'd4, 1'b1);
    check("st_req", memReq, 1);
    check("st_ready", exReady, 0);
    check("st_we", memWe, 1);
    check("st_addr", memAddr, 32'h0000_1000);
    check("st_be", memBe, 4'b1000);
    check("st_wdata", memWdata, 32'hABAB_ABAB);
    tick();
    tick();
    check("st_hold_req", memReq, 1);
    check("st_hold_be", memBe, 4'b1000);
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    check("st_wbv", wbValid, 1);
    check("st_rw", wbRegWrite, 0);
    check("st_err", memError, 0);
    check("st_req_drop", memReq, 0);
    check("st_ready_back", exReady, 1);

    // Half store at 0x2002 lands in upper lanes
    issue(1'b0, 1'b1, 2'b01, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 5'd0, 1'b0);
    check("sth_be", memBe, 4'b1100);
    check("sth_wdata", memWdata, 32'hBEEF_BEEF);
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    check("sth_wbv", wbValid, 1);

    load("ldh_sx", 2'b01, 32'h0000_2002, 1'b1, 32'h8001_0000, 32'hFFFF_8001);
    load("ldh_zx", 2'b01, 32'h0000_2002, 1'b0, 32'h8001_0000, 32'h0000_8001);
    load("ldb_sx", 2'b00, 32'h0000_2001, 1'b1, 32'h1234_8056, 32'hFFFF_FF80);
    load("ldw", 2'b10, 32'h0000_2004, 1'b1, 32'h8765_4321, 32'h8765_4321);

    // Load with no grant times out after four request cycles
    issue(1'b1, 1'b0, 2'b10, 32'h0000_4000, 32'h0, 1'b0, 5'd5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req%0d", i), memReq, 1);
      tick();
    end
    check("to_req_drop", memReq, 0);
    check("to_wbv", wbValid, 1);
    check("to_err", memError, 1);
    check("to_rw", wbRegWrite, 0);
    check("to_ready", exReady, 1);
    tick();
    check("to_err_pulse", memError, 0);

    // Word load at 0x3001
    issue(1'b1, 1'b0, 2'b10, 32'h0000_3001, 32'h0, 1'b0, 5'd6, 1'b1);
`ifdef MEM_MISALIGN_CHECK_EN
    check("mis_req", memReq, 0);
    check("mis_wbv", wbValid, 1);
    check("mis_err", memError, 1);
    check("mis_rw", wbRegWrite, 0);
`else
    check("mis_req", memReq, 1);
    check("mis_addr", memAddr, 32'h0000_3000);
    check("mis_be", memBe, 4'b1111);
    memGnt = 1'b1;
    tick();
    memGnt    = 1'b0;
    memRvalid = 1'b1;
    memRdata  = 32'hDEAD_BEEF;
    tick();
    memRvalid = 1'b0;
    check("mis_wbv", wbValid, 1);
    check("mis_data", wbData, 32'hDEAD_BEEF);
    check("mis_err", memError, 0);
`endif
    tick();

    // Reset asserted while waiting for load data
    issue(1'b1, 1'b0, 2'b10, 32'h0000_5000, 32'h0, 1'b0, 5'd8, 1'b1);
    memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    memRdata = 32'h1111_2222;
    rst_n = 1'b0;
    #1;
    check("rst_wait_req", memReq, 0);
    check("rst_wait_wbv", wbValid, 0);
    check("rst_wait_ready", exReady, 1);
    tick();
    rst_n = 1'b1;
    memRvalid = 1'b1;
    tick();
    memRvalid = 1'b0;
    check("late_rvalid_wbv", wbValid, 0);
    tick();
    check("late_rvalid_wbv2", wbValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
